integral_mc: RTL and testbench

- Parametrised multi-channel integral image generator, the successor to the single-luma AVNT_IP16 core.
- Sits between the sensor/pixel-flow front end and the feature-extraction blocks.
- Per enabled channel and per pixel, computes II(x,y) = sum of all pixels with x'<=x and y'<=y.
- Adds a programmable crop window (HOR/VER), selectable saturate/wrap arithmetic, per-channel enables and a sticky status register.

---
 rtl/integral_mc_pkg.sv | 43 ++++
 rtl/integral_mc_linebuf.sv | 25 ++
 rtl/integral_mc.sv | 247 ++++++++++++++++++++++++
 tb/tb_integral_mc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integral_mc_pkg.sv
// Shared definitions for the multi-channel integral image generator:
// register map, MODE/STATUS bit positions, default widths, FSM states.
package integral_mc_pkg;

    localparam logic [2:0] ADDR_MODE   = 3'd0;
    localparam logic [2:0] ADDR_HOR    = 3'd3;
    localparam logic [2:0] ADDR_VER    = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int MODE_EN  = 0;
    localparam int MODE_SAT = 1;
    localparam int MODE_CH  = 2;
    localparam int ST_OVF   = 0;
    localparam int ST_SHORT = 1;

    localparam int D17_PIXSIZE    = 8;
    localparam int D17_NCH        = 3;
    localparam int D17_MAX_COLS   = 1024;
    localparam int D17_COL_BITS   = 11;
    localparam int D17_IIWORDSIZE = 32;
    localparam int D17_PARSIZE    = 16;

    typedef enum logic [1:0] {IDLE, LINE, GAP, FLUSH} state_t;

    typedef struct packed {
        logic        ovf;
        logic [63:0] v;
    } acc_t;

    // w-bit add of two w-bit operands (w <= 64) with clamp or wrap
    function automatic acc_t add_sat(logic [63:0] a, logic [63:0] b,
                                     int w, logic sat);
        acc_t r;
        logic [64:0] s, m, t;
        s = {1'b0, a} + {1'b0, b};
        m = (65'd1 << w) - 65'd1;
        t = s & m;
        r.ovf = |(s & ~m);
        r.v = (r.ovf && sat) ? m[63:0] : t[63:0];
        return r;
    endfunction

endpackage

// File: rtl/integral_mc_linebuf.sv
// Simple dual-port line buffer: one row of integral words per channel,
// 1-cycle synchronous read, per-channel write enables.
module integral_mc_linebuf #(
    parameter int NCH   = 3,
    parameter int W     = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic [NCH-1:0]   we,
    input  logic [AW-1:0]    wa,
    input  logic [NCH*W-1:0] wd,
    input  logic [AW-1:0]    ra,
    output logic [NCH*W-1:0] rd
);

    logic [NCH*W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++)
            if (we[c]) mem[wa][c*W +: W] <= wd[c*W +: W];
        rd <= mem[ra];
    end

endmodule

// File: rtl/integral_mc.sv
// Multi-channel integral image generator with crop window and sat/wrap.
// Optional squared-pixel integral output II2_o when D17_SQII_EN is defined.
module integral_mc
    import integral_mc_pkg::*;
#(
    parameter int PIXSIZE    = D17_PIXSIZE,
    parameter int NCH        = D17_NCH,
    parameter int MAX_COLS   = D17_MAX_COLS,
    parameter int COL_BITS   = D17_COL_BITS,
    parameter int IIWORDSIZE = D17_IIWORDSIZE,
    parameter int PARSIZE    = D17_PARSIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH*PIXSIZE-1:0]    Y_i,
    input  logic                      frame_valid_i,
    input  logic                      data_valid_i,
    input  logic                      cs_n,
    input  logic [2:0]                addr,
    input  logic [PARSIZE-1:0]        set_data,
    output logic [PARSIZE-1:0]        get_data,
    input  logic                      write_b,
    output logic [NCH*IIWORDSIZE-1:0] II_o,
`ifdef D17_SQII_EN
    output logic [NCH*2*IIWORDSIZE-1:0] II2_o,
`endif
    output logic                      frame_valid_o,
    output logic                      data_valid_o
);

    localparam int AW = $clog2(MAX_COLS);
    localparam int W  = IIWORDSIZE;
    localparam int W2 = 2 * IIWORDSIZE;

    state_t st, st_n;
    logic fl_cnt, fv_q, dv_q;
    logic [PARSIZE-1:0] mode_r, mode_a, mode_n, rd_mux;
    logic [COL_BITS-1:0] hor_r, ver_r, hor_a, ver_a, hor_n, ver_n;
    logic [COL_BITS-1:0] col_cnt, row_cnt, col_cur, s1_col;
    logic [1:0] status, status_n, fvd;
    logic wr, fv_rise, active, take, line_start, line_end;
    logic in_win, sat, ovf_hit, short_hit, s1_v, s1_row0;
    logic [NCH-1:0] chen, ovf1, ovf2, ovf_sq, lb_we;
    logic [NCH-1:0][W-1:0] rowsum, rs_nx, s1_rs, lb_rd, ii_nx;
    acc_t r1, r2;
    logic unused_ok;

    assign wr         = !cs_n && !write_b;
    assign fv_rise    = frame_valid_i && !fv_q;
    assign active     = (st == LINE) || (st == GAP);
    assign take       = active && frame_valid_i && data_valid_i;
    assign line_start = take && !dv_q;
    assign line_end   = active && dv_q && !data_valid_i;
    assign col_cur    = line_start ? '0 : col_cnt;
    assign in_win     = (col_cur < hor_a) && (row_cnt < ver_a);
    assign sat        = mode_a[MODE_SAT];
    assign chen       = mode_a[MODE_CH +: NCH];
    assign short_hit  = line_end && (row_cnt < ver_a) && (col_cnt < hor_a);
    assign ovf_hit    = |(chen & ((ovf1 & {NCH{take && in_win}})
                        | (ovf2 & {NCH{s1_v}}) | ovf_sq));
    assign frame_valid_o = fvd[1];

    always_comb begin
        mode_n = mode_r;
        hor_n  = hor_r;
        ver_n  = ver_r;
        if (wr) begin
            unique case (1'b1)
                addr == ADDR_MODE: mode_n = set_data;
                addr == ADDR_HOR:  hor_n = set_data[COL_BITS-1:0];
                addr == ADDR_VER:  ver_n = set_data[COL_BITS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        status_n = status;
        if (wr && addr == ADDR_STATUS) status_n = status & ~set_data[1:0];
        if (ovf_hit) status_n[ST_OVF] = 1'b1;
        if (short_hit) status_n[ST_SHORT] = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            addr == ADDR_MODE:   rd_mux = mode_r;
            addr == ADDR_HOR:    rd_mux = PARSIZE'(hor_r);
            addr == ADDR_VER:    rd_mux = PARSIZE'(ver_r);
            addr == ADDR_STATUS: rd_mux = PARSIZE'(status);
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE:  if (fv_rise && mode_n[MODE_EN]) st_n = LINE;
            LINE:  if (!frame_valid_i) st_n = FLUSH;
                   else if (!data_valid_i) st_n = GAP;
            GAP:   if (!frame_valid_i) st_n = FLUSH;
                   else if (data_valid_i) st_n = LINE;
            FLUSH: if (fl_cnt) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_comb begin
        r1 = '0;
        r2 = '0;
        rs_nx = rowsum;
        ii_nx = '0;
        ovf1 = '0;
        ovf2 = '0;
        lb_we = '0;
        for (int c = 0; c < NCH; c++) begin
            r1 = add_sat(line_start ? 64'd0 : 64'(rowsum[c]),
                         64'(Y_i[c*PIXSIZE +: PIXSIZE]), W, sat);
            rs_nx[c] = r1.v[W-1:0];
            ovf1[c] = r1.ovf;
            r2 = add_sat(64'(s1_rs[c]), s1_row0 ? 64'd0 : 64'(lb_rd[c]),
                         W, sat);
            ii_nx[c] = chen[c] ? r2.v[W-1:0] : '0;
            ovf2[c] = r2.ovf;
            lb_we[c] = s1_v && chen[c];
        end
    end

    // fv_q resets high so a frame already in progress is not seen as a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            fl_cnt <= 1'b0;
            fv_q <= 1'b1;
            dv_q <= 1'b0;
            mode_r <= '0;
            mode_a <= '0;
            hor_r <= COL_BITS'(MAX_COLS);
            hor_a <= COL_BITS'(MAX_COLS);
            ver_r <= '1;
            ver_a <= '1;
            status <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            rowsum <= '0;
            s1_v <= 1'b0;
            s1_col <= '0;
            s1_row0 <= 1'b0;
            s1_rs <= '0;
            data_valid_o <= 1'b0;
            II_o <= '0;
            fvd <= '0;
            get_data <= '0;
        end else begin
            st <= st_n;
            fl_cnt <= (st == FLUSH) ? !fl_cnt : 1'b0;
            fv_q <= frame_valid_i;
            dv_q <= data_valid_i;
            mode_r <= mode_n;
            hor_r <= hor_n;
            ver_r <= ver_n;
            status <= status_n;
            if (fv_rise) begin
                mode_a <= mode_n;
                hor_a <= hor_n;
                ver_a <= ver_n;
            end
            if (st == IDLE) row_cnt <= '0;
            else if (line_end && row_cnt != '1) row_cnt <= row_cnt + 1'b1;
            if (take) begin
                col_cnt <= (col_cur == '1) ? col_cur : col_cur + 1'b1;
                rowsum <= rs_nx;
                s1_col <= col_cur;
                s1_row0 <= (row_cnt == '0);
                s1_rs <= rs_nx;
            end
            s1_v <= take && in_win;
            data_valid_o <= s1_v;
            if (s1_v) II_o <= ii_nx;
            fvd <= {fvd[0], frame_valid_i && (st_n == LINE || st_n == GAP)};
            get_data <= rd_mux;
        end
    end

    integral_mc_linebuf #(
        .NCH(NCH), .W(W), .DEPTH(MAX_COLS), .AW(AW)
    ) u_lb (
        .clk(clk), .we(lb_we), .wa(s1_col[AW-1:0]), .wd(ii_nx),
        .ra(col_cur[AW-1:0]), .rd(lb_rd)
    );

`ifdef D17_SQII_EN
    logic [NCH-1:0][W2-1:0] rowsum2, rs2_nx, s1_rs2, lb2_rd, ii2_nx;
    logic [NCH-1:0] ovf3, ovf4;
    acc_t r3, r4;
    logic unused_sq;

    always_comb begin
        r3 = '0;
        r4 = '0;
        rs2_nx = rowsum2;
        ii2_nx = '0;
        ovf3 = '0;
        ovf4 = '0;
        for (int c = 0; c < NCH; c++) begin
            r3 = add_sat(line_start ? 64'd0 : 64'(rowsum2[c]),
                         64'(Y_i[c*PIXSIZE +: PIXSIZE])
                         * 64'(Y_i[c*PIXSIZE +: PIXSIZE]), W2, sat);
            rs2_nx[c] = r3.v[W2-1:0];
            ovf3[c] = r3.ovf;
            r4 = add_sat(64'(s1_rs2[c]), s1_row0 ? 64'd0 : 64'(lb2_rd[c]),
                         W2, sat);
            ii2_nx[c] = chen[c] ? r4.v[W2-1:0] : '0;
            ovf4[c] = r4.ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowsum2 <= '0;
            s1_rs2 <= '0;
            II2_o <= '0;
        end else begin
            if (take) begin
                rowsum2 <= rs2_nx;
                s1_rs2 <= rs2_nx;
            end
            if (s1_v) II2_o <= ii2_nx;
        end
    end

    integral_mc_linebuf #(
        .NCH(NCH), .W(W2), .DEPTH(MAX_COLS), .AW(AW)
    ) u_lb2 (
        .clk(clk), .we(lb_we), .wa(s1_col[AW-1:0]), .wd(ii2_nx),
        .ra(col_cur[AW-1:0]), .rd(lb2_rd)
    );

    assign ovf_sq = (ovf3 & {NCH{take && in_win}}) | (ovf4 & {NCH{s1_v}});
    assign unused_sq = ^{r3, r4};
`else
    assign ovf_sq = '0;
`endif

    assign unused_ok = ^{mode_a, s1_col, r1, r2};

endmodule

// File: tb/tb_integral_mc.sv
// Directed bench for integral_mc: rectangle-sum reference model, per-cycle
// scoreboard of outputs and latency, plus literal pins on key results.
module tb_integral_mc;

    localparam int NCH = 3;
    localparam int PIX = 8;
    localparam int W   = 12;
    localparam int MC  = 128;
    localparam int CB  = 8;
    localparam int PS  = 16;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [NCH*PIX-1:0] Y_i;
    logic frame_valid_i, data_valid_i, cs_n, write_b;
    logic [2:0] addr;
    logic [PS-1:0] set_data, get_data;
    logic [NCH*W-1:0] II_o;
    logic frame_valid_o, data_valid_o;

    integral_mc #(
        .PIXSIZE(PIX), .NCH(NCH), .MAX_COLS(MC), .COL_BITS(CB),
        .IIWORDSIZE(W), .PARSIZE(PS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Y_i(Y_i),
        .frame_valid_i(frame_valid_i), .data_valid_i(data_valid_i),
        .cs_n(cs_n), .addr(addr), .set_data(set_data),
        .get_data(get_data), .write_b(write_b), .II_o(II_o),
        .frame_valid_o(frame_valid_o), .data_valid_o(data_valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors = 0;
    int outs = 0;
    int first_out = -1;
    int first_drive = -1;
    logic [NCH*W-1:0] last_ii = '0;
    logic [NCH*W-1:0] exp_q[$];
    int expc_q[$];

    always @(negedge clk) begin
        if (rst_n && data_valid_o) begin
            outs++;
            last_ii = II_o;
            if (first_out < 0) first_out = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output ii=%h cyc=%0d", II_o, cyc);
            end else begin
                logic [NCH*W-1:0] e;
                int ec;
                e = exp_q.pop_front();
                ec = expc_q.pop_front();
                if (II_o !== e || cyc != ec || frame_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL ii_output got=%h want=%h cyc=%0d want_cyc=%0d fv_o=%b",
                             II_o, e, cyc, ec, frame_valid_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input int d);
        cs_n = 1'b0;
        write_b = 1'b0;
        addr = a;
        set_data = PS'(d);
        tick();
        cs_n = 1'b1;
        write_b = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output int d);
        addr = a;
        tick();
        d = int'(get_data);
    endtask

    function automatic int mode(input int en, input int s);
        return (en << 2) | (s << 1) | 1;
    endfunction

    function automatic int pixv(input int pat, input int c, input int x, input int y);
        if (pat == 0) return 1;
        if (pat == 1) return x + 4 * y + c;
        return 255;
    endfunction

    // integral = plain rectangle sum, then clamp or modulo on the word size
    function automatic logic [NCH*W-1:0] model_ii(input int pat, input int x,
            input int y, input logic [NCH-1:0] en, input logic s);
        logic [NCH*W-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            longint sum, v;
            sum = 0;
            for (int yy = 0; yy <= y; yy++)
                for (int xx = 0; xx <= x; xx++)
                    sum += pixv(pat, c, xx, yy);
            if (!en[c]) v = 0;
            else if (sum > MAXV) v = s ? MAXV : sum % (MAXV + 1);
            else v = sum;
            r[c*W +: W] = W'(v);
        end
        return r;
    endfunction

    function automatic longint pack3(input int c2, input int c1, input int c0);
        return (longint'(c2) << (2 * W)) | (longint'(c1) << W) | longint'(c0);
    endfunction

    task automatic drive_pix(input int pat, input int x, input int y);
        data_valid_i = 1'b1;
        for (int c = 0; c < NCH; c++) Y_i[c*PIX +: PIX] = PIX'(pixv(pat, c, x, y));
    endtask

    task automatic run_frame(input int cols, input int rows, input int pat,
            input int hor, input int ver, input logic [NCH-1:0] en,
            input logic s, input int mid_hor);
        outs = 0;
        first_out = -1;
        first_drive = -1;
        tick();
        frame_valid_i = 1'b1;
        tick();
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                drive_pix(pat, x, y);
                if (x < hor && y < ver) begin
                    exp_q.push_back(model_ii(pat, x, y, en, s));
                    expc_q.push_back(cyc + 2);
                end
                if (first_drive < 0) first_drive = cyc;
                tick();
            end
            data_valid_i = 1'b0;
            Y_i = '0;
            if (mid_hor > 0 && y == 1) begin
                cs_n = 1'b0;
                write_b = 1'b0;
                addr = 3'd3;
                set_data = PS'(mid_hor);
            end
            tick();
            cs_n = 1'b1;
            write_b = 1'b1;
            tick();
        end
        frame_valid_i = 1'b0;
        repeat (8) tick();
        chk("missing_outputs", exp_q.size(), 0);
        exp_q.delete();
        expc_q.delete();
    endtask

    initial begin
        int d;
        rst_n = 1'b0;
        cs_n = 1'b1;
        write_b = 1'b1;
        addr = '0;
        set_data = '0;
        Y_i = '0;
        frame_valid_i = 1'b0;
        data_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ii", II_o, 0);
        chk("rst_dv", data_valid_o, 0);
        chk("rst_fv", frame_valid_o, 0);
        chk("rst_get", get_data, 0);
        rst_n = 1'b1;
        tick();
        rd_reg(3'd3, d); chk("rst_hor", d, MC);
        rd_reg(3'd4, d); chk("rst_ver", d, (1 << CB) - 1);
        rd_reg(3'd0, d); chk("rst_mode", d, 0);
        rd_reg(3'd5, d); chk("rst_status", d, 0);
        wr_reg(3'd3, 4);
        wr_reg(3'd4, 3);
        wr_reg(3'd0, mode(7, 0));
        rd_reg(3'd7, d); chk("unmapped", d, 0);
        rd_reg(3'd3, d); chk("hor_rb", d, 4);

        run_frame(4, 3, 0, 4, 3, 3'b111, 1'b0, 0);
        chk("ones_outs", outs, 12);
        chk("ones_last", last_ii, pack3(12, 12, 12));
        chk("latency", first_out - first_drive, 2);

        run_frame(4, 3, 1, 4, 3, 3'b111, 1'b0, 0);
        chk("ramp_outs", outs, 12);
        chk("ramp_last", last_ii, pack3(90, 78, 66));

        wr_reg(3'd3, 64);
        wr_reg(3'd4, 64);
        wr_reg(3'd0, mode(7, 1));
        run_frame(64, 64, 2, 64, 64, 3'b111, 1'b1, 0);
        chk("sat_last", last_ii, pack3(4095, 4095, 4095));
        rd_reg(3'd5, d); chk("sat_ovf", d & 1, 1);
        wr_reg(3'd5, 1);
        rd_reg(3'd5, d); chk("ovf_clear", d & 1, 0);

        wr_reg(3'd0, mode(7, 0));
        run_frame(64, 64, 2, 64, 64, 3'b111, 1'b0, 0);
        chk("wrap_last", last_ii, pack3(0, 0, 0));
        rd_reg(3'd5, d); chk("wrap_ovf", d & 1, 1);
        wr_reg(3'd5, 1);
        rd_reg(3'd5, d); chk("wrap_clear", d & 1, 0);

        wr_reg(3'd3, 4);
        wr_reg(3'd4, 3);
        run_frame(8, 6, 1, 4, 3, 3'b111, 1'b0, 6);
        chk("crop_outs", outs, 12);
        run_frame(8, 6, 1, 6, 3, 3'b111, 1'b0, 0);
        chk("crop_next_outs", outs, 18);

        wr_reg(3'd3, 4);
        wr_reg(3'd0, mode(2, 0));
        run_frame(4, 3, 1, 4, 3, 3'b010, 1'b0, 0);
        chk("chen_last", last_ii, pack3(0, 78, 0));

        wr_reg(3'd0, mode(7, 0));
        tick();
        frame_valid_i = 1'b1;
        tick();
        for (int x = 0; x < 4; x++) begin
            drive_pix(0, x, 0);
            exp_q.push_back(model_ii(0, x, 0, 3'b111, 1'b0));
            expc_q.push_back(cyc + 2);
            tick();
        end
        data_valid_i = 1'b0;
        repeat (2) tick();
        drive_pix(0, 0, 1);
        tick();
        drive_pix(0, 1, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ii", II_o, 0);
        chk("midrst_dv", data_valid_o, 0);
        chk("midrst_fv", frame_valid_o, 0);
        exp_q.delete();
        expc_q.delete();
        tick();
        rst_n = 1'b1;
        data_valid_i = 1'b0;
        outs = 0;
        wr_reg(3'd3, 4);
        wr_reg(3'd4, 3);
        wr_reg(3'd0, mode(7, 0));
        for (int y = 2; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                drive_pix(0, x, y);
                tick();
            end
            data_valid_i = 1'b0;
            repeat (2) tick();
        end
        frame_valid_i = 1'b0;
        repeat (8) tick();
        chk("ignored_frame_outs", outs, 0);
        run_frame(4, 3, 0, 4, 3, 3'b111, 1'b0, 0);
        chk("post_rst_outs", outs, 12);
        chk("post_rst_last", last_ii, pack3(12, 12, 12));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
